risc_spm_cpu: RTL and testbench
===============================

Name: risc_spm_cpu

Overview:
- 8-bit stored-program RISC processor with an internal 256x8 unified program/data memory, four 8-bit general registers R0..R3, a PC, a zero flag and a multi-cycle controller.
- Top-level CPU of the SPM design; the debug buses expose internal datapath traffic.
- Memory is preloaded by hierarchical reference; there is no external load port.

Parameters:
- word_size, 8, datapath, register, memory-word and address width.
- memory_size, 256, number of memory words (addresses 0..255).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_bus  output  8  Bus_2: value currently driven toward registers, address register, PC or memory write data.
- address_bus  output  8  address register output; current memory address.
- memory_bus  output  8  memory read data at address_bus.
- instruction_bus  output  8  instruction register contents.

Behaviour:
- Hierarchy: memory instance named M2_MEM containing array memory[0:255] of word_size bits. Memory is never cleared by rst.
- Memory: combinational read at address_bus; synchronous write on the rising clk edge when the write strobe is asserted.
- Reset (rst low, asynchronous): PC=0, address register=0, IR=0, R0..R3=0, Z=0, FSM=S_idle. All debug outputs follow from these zeroed registers.
- Instruction format: [7:4] opcode, [3:2] src, [1:0] dest.
- Opcodes:
  - NOP 0000: any low nibble is ignored.
  - ADD 0001: dest<=dest+src.
  - SUB 0010: dest<=dest-src.
  - AND 0011: dest<=dest&src.
  - NOT 0100: dest<=~src.
  - RD 0101: dest<=mem[next word].
  - WR 0110: mem[next word]<=src.
  - BR 0111: PC<=mem[next word].
  - BRZ 1000: if Z then BR, else skip the address word.
  - CMP 1001: compute dest-src, update Z only; no register writeback.
  - HALT 1111.
  - All other opcodes execute as NOP.
- Arithmetic: modulo 256, no carry/overflow flag.
- Z flag: Z=1 iff the 8-bit result is 0. Updated only by ADD, SUB, AND, NOT and CMP; held by every other instruction.
- FSM states and transitions:
  - S_idle -> S_fet1.
  - S_fet1: AR<=PC, PC<=PC+1 -> S_fet2.
  - S_fet2: IR<=mem[AR] -> S_dec.
  - S_dec:
    - NOP/unknown -> S_fet1.
    - ADD/SUB/AND/NOT/CMP -> S_ex1 (operands latched).
    - RD -> S_rd1; WR -> S_wr1; BR -> S_br1.
    - BRZ: Z=1 -> S_br1; Z=0: PC<=PC+1, -> S_fet1.
    - HALT -> S_halt.
  - S_ex1: write result / update Z -> S_fet1.
  - S_rd1: AR<=PC, PC<=PC+1 -> S_rd2. S_rd2: AR<=mem[AR] -> S_rd3. S_rd3: dest<=mem[AR] -> S_fet1.
  - S_wr1/S_wr2: same address sequence as RD; S_wr3: mem[AR]<=src -> S_fet1.
  - S_br1: AR<=PC -> S_br2. S_br2: PC<=mem[AR] -> S_fet1.
  - S_halt: hold all state until rst.
- Latency (cycles, including fetch): NOP 3, ALU/CMP 4, RD/WR 6, BR taken 5, BRZ not taken 3.
- PC wraps 255->0.
- Operand hazards cannot occur: the machine is strictly sequential.
- rst asserted mid-instruction aborts it immediately; any memory write not yet clocked is lost.

Test Plan:
- Load/sub/compare: mem[0..5]={0x50,129,0x51,130,0x21,0x96}, mem[129]=2, mem[130]=3, mem[139]=0xF0, rest 0, release rst -> R0=2, R1=1, R2=0. CMP R1,R2 leaves Z=0, R1 unchanged. PC then runs through NOPs (mem[128..130]=1,2,3 treated as NOP) to 139 and stays in S_halt with PC=140.
- Reset mid-RD: assert rst while in S_rd2 -> PC=0, R=0, FSM S_idle asynchronously; refetch from address 0 after release.
- ADD wrap: R0=0xFF, R1=0x01, ADD src R1 dest R0 -> R0=0x00, Z=1.
- WR then RD: WR R2(=0x5A) to 200, then RD 200 into R3 -> mem[200]=0x5A, R3=0x5A.
- BRZ: with Z=1, branch to 0x20 -> PC=0x20. With Z=0 -> address word skipped, PC=instruction address+2.
- NOT: R1=0x0F, NOT src R1 dest R3 -> R3=0xF0, Z=0. HALT freezes registers for 100+ cycles.

Source files
------------

// File: rtl/risc_spm_cpu_if.sv
// Debug bus bundle of the SPM CPU: the four internal datapath buses made visible
// to the outside world.
interface risc_spm_cpu_if #(parameter int word_size = 8);
    logic [word_size-1:0] data_bus;
    logic [word_size-1:0] address_bus;
    logic [word_size-1:0] memory_bus;
    logic [word_size-1:0] instruction_bus;

    modport master (output data_bus, output address_bus, output memory_bus, output instruction_bus);
    modport slave  (input  data_bus, input  address_bus, input  memory_bus, input  instruction_bus);
endinterface

// File: rtl/risc_spm_cpu.sv
// 8-bit stored-program RISC CPU with a unified 256x8 program/data memory,
// four general registers, a zero flag and a multi-cycle controller.
module risc_spm_memory #(
    parameter int word_size   = 8,
    parameter int memory_size = 256
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic [word_size-1:0] address,
    input  logic [word_size-1:0] data_in,
    output logic [word_size-1:0] data_out
);
    // Contents survive reset; they are preloaded from outside by hierarchical reference.
    logic [word_size-1:0] memory [0:memory_size-1];

    assign data_out = memory[address];

    always_ff @(posedge clk) begin
        if (write)
            memory[address] <= data_in;
    end
endmodule

module risc_spm_cpu #(
    parameter int word_size   = 8,
    parameter int memory_size = 256
) (
    input  logic           clk,
    input  logic           rst,
    risc_spm_cpu_if.master dbg
);
    localparam logic [3:0] s_idle = 4'd0;
    localparam logic [3:0] s_fet1 = 4'd1;
    localparam logic [3:0] s_fet2 = 4'd2;
    localparam logic [3:0] s_dec  = 4'd3;
    localparam logic [3:0] s_ex1  = 4'd4;
    localparam logic [3:0] s_rd1  = 4'd5;
    localparam logic [3:0] s_rd2  = 4'd6;
    localparam logic [3:0] s_rd3  = 4'd7;
    localparam logic [3:0] s_wr1  = 4'd8;
    localparam logic [3:0] s_wr2  = 4'd9;
    localparam logic [3:0] s_wr3  = 4'd10;
    localparam logic [3:0] s_br1  = 4'd11;
    localparam logic [3:0] s_br2  = 4'd12;
    localparam logic [3:0] s_halt = 4'd13;

    localparam logic [3:0] op_add  = 4'b0001;
    localparam logic [3:0] op_sub  = 4'b0010;
    localparam logic [3:0] op_and  = 4'b0011;
    localparam logic [3:0] op_not  = 4'b0100;
    localparam logic [3:0] op_rd   = 4'b0101;
    localparam logic [3:0] op_wr   = 4'b0110;
    localparam logic [3:0] op_br   = 4'b0111;
    localparam logic [3:0] op_brz  = 4'b1000;
    localparam logic [3:0] op_cmp  = 4'b1001;
    localparam logic [3:0] op_halt = 4'b1111;

    localparam logic [word_size-1:0] one = 1;

    logic [3:0]           state;
    logic [word_size-1:0] pc, ar, ir;
    logic [word_size-1:0] regs [0:3];
    logic                 zflag;
    logic [word_size-1:0] opa, opb;
    logic [word_size-1:0] alu_out, data_bus, memory_bus;
    logic                 mem_write;

    assign mem_write = (state == s_wr3);

    risc_spm_memory #(.word_size(word_size), .memory_size(memory_size)) M2_MEM (
        .clk      (clk),
        .write    (mem_write),
        .address  (ar),
        .data_in  (data_bus),
        .data_out (memory_bus)
    );

    // opa is the latched destination operand, opb the latched source operand.
    always_comb begin
        alu_out = '0;
        case (ir[7:4])
            op_add:         alu_out = opa + opb;
            op_sub, op_cmp: alu_out = opa - opb;
            op_and:         alu_out = opa & opb;
            op_not:         alu_out = ~opb;
            default:        alu_out = '0;
        endcase
    end

    // Bus_2: the single value each state moves into AR, IR, PC, a register or memory.
    always_comb begin
        data_bus = pc;
        case (state)
            s_fet2, s_rd2, s_rd3, s_wr2, s_br2: data_bus = memory_bus;
            s_ex1:                              data_bus = alu_out;
            s_wr3:                              data_bus = regs[ir[3:2]];
            default:                            data_bus = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= s_idle;
            pc    <= '0;
            ar    <= '0;
            ir    <= '0;
            zflag <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                s_idle: state <= s_fet1;
                s_fet1: begin
                    ar    <= data_bus;
                    pc    <= pc + one;
                    state <= s_fet2;
                end
                s_fet2: begin
                    ir    <= data_bus;
                    state <= s_dec;
                end
                s_dec: begin
                    opa <= regs[ir[1:0]];
                    opb <= regs[ir[3:2]];
                    case (ir[7:4])
                        op_add, op_sub, op_and, op_not, op_cmp: state <= s_ex1;
                        op_rd:   state <= s_rd1;
                        op_wr:   state <= s_wr1;
                        op_br:   state <= s_br1;
                        op_halt: state <= s_halt;
                        op_brz: begin
                            // Untaken branch steps over its address word.
                            if (zflag)
                                state <= s_br1;
                            else begin
                                pc    <= pc + one;
                                state <= s_fet1;
                            end
                        end
                        default: state <= s_fet1;
                    endcase
                end
                s_ex1: begin
                    if (ir[7:4] != op_cmp)
                        regs[ir[1:0]] <= data_bus;
                    zflag <= (data_bus == '0);
                    state <= s_fet1;
                end
                s_rd1, s_wr1: begin
                    ar    <= data_bus;
                    pc    <= pc + one;
                    state <= (state == s_rd1) ? s_rd2 : s_wr2;
                end
                s_rd2, s_wr2: begin
                    ar    <= data_bus;
                    state <= (state == s_rd2) ? s_rd3 : s_wr3;
                end
                s_rd3: begin
                    regs[ir[1:0]] <= data_bus;
                    state         <= s_fet1;
                end
                s_wr3: state <= s_fet1;
                s_br1: begin
                    ar    <= data_bus;
                    state <= s_br2;
                end
                s_br2: begin
                    pc    <= data_bus;
                    state <= s_fet1;
                end
                s_halt:  state <= s_halt;
                default: state <= s_idle;
            endcase
        end
    end

    assign dbg.data_bus        = data_bus;
    assign dbg.address_bus     = ar;
    assign dbg.memory_bus      = memory_bus;
    assign dbg.instruction_bus = ir;
endmodule

// File: tb/tb_risc_spm_cpu.sv
// Self-checking bench for risc_spm_cpu: ALU vector table, directed multi-cycle
// sequences and random programs against an instruction-level reference model.
module tb_risc_spm_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    risc_spm_cpu_if bus ();
    risc_spm_cpu dut (.clk(clk), .rst(rst), .dbg(bus));

    always #5 clk = ~clk;

    // Reference model: architectural state only, one whole instruction per step.
    logic [7:0] m_mem [256];
    logic [7:0] m_reg [4];
    logic [7:0] m_pc;
    logic       m_z;
    logic       m_halt;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_r0;
        logic       exp_z;
    } alu_vec_t;

    alu_vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input int addr, input logic [7:0] val);
        dut.M2_MEM.memory[addr] <= val;
        m_mem[addr] = val;
    endtask

    // Holds the CPU in reset and clears memory so each test starts from a known image.
    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++)
            poke(i, 8'h00);
        m_pc = 8'h00;
        m_z = 1'b0;
        m_halt = 1'b0;
        for (int i = 0; i < 4; i++)
            m_reg[i] = 8'h00;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_step(output int lat);
        logic [7:0] inst, res, addr;
        logic [1:0] s, d;
        inst = m_mem[m_pc];
        s = inst[3:2];
        d = inst[1:0];
        m_pc = m_pc + 8'd1;
        lat = 3;
        case (inst[7:4])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h9: begin
                case (inst[7:4])
                    4'h1:    res = m_reg[d] + m_reg[s];
                    4'h3:    res = m_reg[d] & m_reg[s];
                    4'h4:    res = ~m_reg[s];
                    default: res = m_reg[d] - m_reg[s];
                endcase
                if (inst[7:4] != 4'h9)
                    m_reg[d] = res;
                m_z = (res == 8'h00);
                lat = 4;
            end
            4'h5: begin
                addr = m_mem[m_pc];
                m_pc = m_pc + 8'd1;
                m_reg[d] = m_mem[addr];
                lat = 6;
            end
            4'h6: begin
                addr = m_mem[m_pc];
                m_pc = m_pc + 8'd1;
                m_mem[addr] = m_reg[s];
                lat = 6;
            end
            4'h7: begin
                m_pc = m_mem[m_pc];
                lat = 5;
            end
            4'h8: begin
                if (m_z) begin
                    m_pc = m_mem[m_pc];
                    lat = 5;
                end else
                    m_pc = m_pc + 8'd1;
            end
            4'hF: m_halt = 1'b1;
            default: lat = 3;
        endcase
    endtask

    task automatic compare_model(input string tag);
        checkOutput({tag, " pc"}, dut.pc, m_pc);
        checkOutput({tag, " z"}, {7'd0, dut.zflag}, {7'd0, m_z});
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s r%0d", tag, i), dut.regs[i], m_reg[i]);
    endtask

    initial begin
        int lat;
        logic [7:0] rb;

        vecs[0]  = '{4'h1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1]  = '{4'h1, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[2]  = '{4'h2, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[3]  = '{4'h2, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[4]  = '{4'h3, 8'hF0, 8'h0F, 8'h00, 1'b1};
        vecs[5]  = '{4'h3, 8'h3C, 8'h0F, 8'h0C, 1'b0};
        vecs[6]  = '{4'h4, 8'h55, 8'h0F, 8'hF0, 1'b0};
        vecs[7]  = '{4'h4, 8'h55, 8'hFF, 8'h00, 1'b1};
        vecs[8]  = '{4'h9, 8'h07, 8'h07, 8'h07, 1'b1};
        vecs[9]  = '{4'h9, 8'h07, 8'h08, 8'h07, 1'b0};
        vecs[10] = '{4'hA, 8'h11, 8'h22, 8'h11, 1'b0};
        vecs[11] = '{4'h0, 8'h33, 8'h44, 8'h33, 1'b0};

        #2 rst = 1'b0;
        hold_reset();
        @(negedge clk);
        checkOutput("reset pc", dut.pc, 8'h00);
        checkOutput("reset address_bus", bus.address_bus, 8'h00);
        checkOutput("reset instruction_bus", bus.instruction_bus, 8'h00);
        checkOutput("reset data_bus", bus.data_bus, 8'h00);

        // ALU table: RD R0<-a, RD R1<-b, op src R1 dest R0, HALT.
        for (int v = 0; v < 12; v++) begin
            hold_reset();
            poke(0, 8'h50); poke(1, 8'd100);
            poke(2, 8'h51); poke(3, 8'd101);
            poke(4, {vecs[v].op, 4'b0100});
            poke(5, 8'hF0);
            poke(100, vecs[v].a); poke(101, vecs[v].b);
            release_reset();
            applyStimulus(20);
            checkOutput($sformatf("vec%0d r0", v), dut.regs[0], vecs[v].exp_r0);
            checkOutput($sformatf("vec%0d r1", v), dut.regs[1], vecs[v].b);
            checkOutput($sformatf("vec%0d z", v), {7'd0, dut.zflag}, {7'd0, vecs[v].exp_z});
            checkOutput($sformatf("vec%0d pc", v), dut.pc, 8'h06);
        end

        // Load, subtract, compare, then a long NOP run into HALT at 139.
        hold_reset();
        poke(0, 8'h50); poke(1, 8'd129); poke(2, 8'h51); poke(3, 8'd130);
        poke(4, 8'h21); poke(5, 8'h96);
        poke(128, 8'd1); poke(129, 8'd2); poke(130, 8'd3); poke(139, 8'hF0);
        release_reset();
        applyStimulus(21);
        checkOutput("plan r0", dut.regs[0], 8'h02);
        checkOutput("plan r1", dut.regs[1], 8'h01);
        checkOutput("plan r2", dut.regs[2], 8'h00);
        checkOutput("plan z", {7'd0, dut.zflag}, 8'h00);
        applyStimulus(402);
        checkOutput("plan halt pc", dut.pc, 8'd140);
        checkOutput("plan halt address_bus", bus.address_bus, 8'd139);
        checkOutput("plan halt instruction_bus", bus.instruction_bus, 8'hF0);
        checkOutput("plan halt memory_bus", bus.memory_bus, 8'hF0);
        applyStimulus(120);
        checkOutput("plan frozen pc", dut.pc, 8'd140);
        checkOutput("plan frozen r0", dut.regs[0], 8'h02);

        // Asynchronous reset while the second RD sits in its address-fetch step.
        hold_reset();
        poke(0, 8'h50); poke(1, 8'd129); poke(2, 8'h51); poke(3, 8'd130);
        poke(4, 8'hF0); poke(129, 8'd2); poke(130, 8'd3);
        release_reset();
        applyStimulus(11);
        checkOutput("midrd pre r0", dut.regs[0], 8'h02);
        rst = 1'b0;
        #1;
        checkOutput("midrd pc", dut.pc, 8'h00);
        checkOutput("midrd r0", dut.regs[0], 8'h00);
        checkOutput("midrd address_bus", bus.address_bus, 8'h00);
        checkOutput("midrd instruction_bus", bus.instruction_bus, 8'h00);
        applyStimulus(2);
        release_reset();
        applyStimulus(7);
        checkOutput("midrd refetch r0", dut.regs[0], 8'h02);
        checkOutput("midrd refetch pc", dut.pc, 8'h02);
        checkOutput("midrd refetch r1", dut.regs[1], 8'h00);
        applyStimulus(6);
        checkOutput("midrd second r1", dut.regs[1], 8'h03);

        // WR R2 to 200, then RD 200 into R3.
        hold_reset();
        poke(0, 8'h52); poke(1, 8'd150); poke(150, 8'h5A);
        poke(2, 8'h68); poke(3, 8'd200);
        poke(4, 8'h53); poke(5, 8'd200); poke(6, 8'hF0);
        release_reset();
        applyStimulus(22);
        checkOutput("wrrd mem200", dut.M2_MEM.memory[200], 8'h5A);
        checkOutput("wrrd r3", dut.regs[3], 8'h5A);
        checkOutput("wrrd pc", dut.pc, 8'h07);

        // BRZ taken after SUB R0,R0 sets Z.
        hold_reset();
        poke(0, 8'h20); poke(1, 8'h80); poke(2, 8'h20); poke(8'h20, 8'hF0);
        release_reset();
        applyStimulus(10);
        checkOutput("brz taken pc", dut.pc, 8'h20);
        applyStimulus(3);
        checkOutput("brz taken halt pc", dut.pc, 8'h21);

        // BRZ not taken after NOT leaves a non-zero result.
        hold_reset();
        poke(0, 8'h41); poke(1, 8'h80); poke(2, 8'h20); poke(3, 8'hF0);
        release_reset();
        applyStimulus(8);
        checkOutput("brz skip pc", dut.pc, 8'h03);
        checkOutput("brz skip r1", dut.regs[1], 8'hFF);

        // NOT into R3, then HALT must freeze everything.
        hold_reset();
        poke(0, 8'h51); poke(1, 8'd100); poke(100, 8'h0F);
        poke(2, 8'h47); poke(3, 8'hF0);
        release_reset();
        applyStimulus(11);
        checkOutput("not r3", dut.regs[3], 8'hF0);
        checkOutput("not z", {7'd0, dut.zflag}, 8'h00);
        applyStimulus(123);
        checkOutput("not frozen r3", dut.regs[3], 8'hF0);
        checkOutput("not frozen r1", dut.regs[1], 8'h0F);
        checkOutput("not frozen pc", dut.pc, 8'h04);

        // Random memory images executed against the reference model.
        for (int run = 0; run < 4; run++) begin
            hold_reset();
            for (int i = 0; i < 256; i++) begin
                rb = 8'($urandom_range(0, 255));
                if (rb[7:4] == 4'hF)
                    rb[7:4] = 4'h0;
                poke(i, rb);
            end
            release_reset();
            applyStimulus(1);
            for (int n = 0; n < 40; n++) begin
                model_step(lat);
                applyStimulus(lat);
                compare_model($sformatf("rand%0d.%0d", run, n));
            end
            for (int i = 0; i < 256; i++)
                checkOutput($sformatf("rand%0d mem%0d", run, i), dut.M2_MEM.memory[i], m_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
